// File: rtl/dds_pkg.sv
// Shared DDS definitions: phase-step width and type, plus the sweep FSM state encoding.
package dds_pkg;

  localparam int DDS_PHASE_W = 32;

  typedef logic [DDS_PHASE_W-1:0] phase_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage : dds_pkg

// File: rtl/dds_freq_sweep_dwell_timer.sv
// Loadable down-counter that sets how long each sweep point is held.
// A load takes priority over counting; the count stops at zero.
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] load_val,
  output logic [DWELL_W-1:0] value,
  output logic               zero
);

  logic [DWELL_W-1:0] r_count;

  // Counter register: load, else count down toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {DWELL_W{1'b0}};
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != {DWELL_W{1'b0}})) begin
      r_count <= r_count - {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign value = r_count;
  assign zero  = (r_count == {DWELL_W{1'b0}});

endmodule : dwell_timer

// File: rtl/dds_freq_sweep.sv
// Linear phase_step ramp generator feeding dds_core; single or continuous sweeps.
// Each point is held for max(dwell_cycles,1) cycles; the ramp clamps at the stop value.
module dds_freq_sweep
  import dds_pkg::*;
#(
  parameter int PHASE_W = DDS_PHASE_W,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [PHASE_W-1:0] start_step,
  input  logic [PHASE_W-1:0] stop_step,
  input  logic [PHASE_W-1:0] step_inc,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic [PHASE_W-1:0] phase_step,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  sweep_state_e       r_state;
  sweep_state_e       w_state_nxt;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  logic [PHASE_W-1:0] r_start, r_stop, r_inc;
  logic               r_cont;
  logic [DWELL_W-1:0] r_dwell_m1;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic               w_latch;
  logic               w_load;
  logic [DWELL_W-1:0] w_load_val;
  logic [DWELL_W-1:0] w_dwell_m1_in;
  logic [DWELL_W-1:0] w_dwell_val;
  logic               w_dwell_zero;
  logic               w_dec;
  logic [PHASE_W-1:0] w_first_in;
  logic [PHASE_W-1:0] w_first_lat;
  logic [PHASE_W:0]   w_sum;
  logic [PHASE_W-1:0] w_next_step;

  // A dwell of 0 behaves as 1, so the reload value is never below zero.
  assign w_dwell_m1_in = (dwell_cycles == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                       : dwell_cycles - {{(DWELL_W-1){1'b0}}, 1'b1};

  // A start above stop collapses the sweep to the single stop point.
  assign w_first_in  = (start_step > stop_step) ? stop_step : start_step;
  assign w_first_lat = (r_start > r_stop) ? r_stop : r_start;

  // Carry out or a zero increment both force the stop value, so the ramp cannot wrap or stall.
  assign w_sum       = {1'b0, r_phase} + {1'b0, r_inc};
  assign w_next_step = ((r_inc == {PHASE_W{1'b0}}) || w_sum[PHASE_W] ||
                        (w_sum[PHASE_W-1:0] >= r_stop)) ? r_stop : w_sum[PHASE_W-1:0];

  assign w_dec = (r_state == SWEEP) && (w_dwell_val != {DWELL_W{1'b0}});

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .dec      (w_dec),
    .load_val (w_load_val),
    .value    (w_dwell_val),
    .zero     (w_dwell_zero)
  );

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_latch     = 1'b0;
    w_load      = 1'b0;
    w_load_val  = r_dwell_m1;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_latch     = 1'b1;
          w_phase_nxt = w_first_in;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
          w_load_val  = w_dwell_m1_in;
          w_state_nxt = SWEEP;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      SWEEP: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end else if (!w_dwell_zero) begin
          w_phase_nxt = r_phase;
        end else if (r_phase != r_stop) begin
          w_phase_nxt = w_next_step;
          w_load      = 1'b1;
        end else if (!r_cont) begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_phase_nxt = w_first_lat;
          w_wrap_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, output and latched-setup registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_phase    <= {PHASE_W{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
      r_start    <= {PHASE_W{1'b0}};
      r_stop     <= {PHASE_W{1'b0}};
      r_inc      <= {PHASE_W{1'b0}};
      r_cont     <= 1'b0;
      r_dwell_m1 <= {DWELL_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
      if (w_latch) begin
        r_start    <= start_step;
        r_stop     <= stop_step;
        r_inc      <= step_inc;
        r_cont     <= continuous;
        r_dwell_m1 <= w_dwell_m1_in;
      end else begin
        r_start    <= r_start;
        r_stop     <= r_stop;
        r_inc      <= r_inc;
        r_cont     <= r_cont;
        r_dwell_m1 <= r_dwell_m1;
      end
    end
  end

  assign phase_step = r_phase;
  assign busy       = r_busy;
  assign done       = r_done;
  assign wrap       = r_wrap;

endmodule : dds_freq_sweep

// File: tb/tb_dds_freq_sweep.sv
// Directed self-checking bench for dds_freq_sweep with hand-computed sweep sequences.
module tb_dds_freq_sweep;
  import dds_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        continuous;
  logic [31:0] start_step;
  logic [31:0] stop_step;
  logic [31:0] step_inc;
  logic [15:0] dwell_cycles;
  logic [31:0] phase_step;
  logic        busy;
  logic        done;
  logic        wrap;

  int checks;
  int failures;

  dds_freq_sweep #(.PHASE_W(32), .DWELL_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .continuous   (continuous),
    .start_step   (start_step),
    .stop_step    (stop_step),
    .step_inc     (step_inc),
    .dwell_cycles (dwell_cycles),
    .phase_step   (phase_step),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_point(input string tag, input logic [31:0] exp_phase,
                             input logic exp_busy, input logic exp_done, input logic exp_wrap);
    check({tag, ".phase"}, phase_step, exp_phase);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, exp_busy});
    check({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
    check({tag, ".wrap"}, {31'd0, wrap}, {31'd0, exp_wrap});
  endtask

  task automatic load_setup(input logic [31:0] s, input logic [31:0] e, input logic [31:0] inc,
                            input logic [15:0] d, input logic c);
    start_step   = s;
    stop_step    = e;
    step_inc     = inc;
    dwell_cycles = d;
    continuous   = c;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    load_setup(32'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    step();
    step();
    check_point("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check_point("idle_after_reset", 32'd0, 1'b0, 1'b0, 1'b0);

    // Basic ramp: 100,110,120,130 each 3 cycles, then done.
    load_setup(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      check_point("ramp", 32'd100 + 32'd10 * 32'(i / 3), 1'b1, 1'b0, 1'b0);
      step();
    end
    check_point("ramp_done", 32'd130, 1'b0, 1'b1, 1'b0);
    step();
    check_point("ramp_after", 32'd130, 1'b0, 1'b0, 1'b0);

    // Clamp with dwell 0: 100,115,130 one cycle each.
    load_setup(32'd100, 32'd130, 32'd15, 16'd0, 1'b0);
    pulse_start();
    check_point("clamp0", 32'd100, 1'b1, 1'b0, 1'b0);
    step();
    check_point("clamp1", 32'd115, 1'b1, 1'b0, 1'b0);
    step();
    check_point("clamp2", 32'd130, 1'b1, 1'b0, 1'b0);
    step();
    check_point("clamp_done", 32'd130, 1'b0, 1'b1, 1'b0);

    // Overflow clamp: FFFFFFF0 x2, FFFFFFFF x2, done.
    load_setup(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h0000_0020, 16'd2, 1'b0);
    pulse_start();
    check_point("ovf0", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    step();
    check_point("ovf1", 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    step();
    check_point("ovf2", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step();
    check_point("ovf3", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step();
    check_point("ovf_done", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);

    // Start above stop: single point at stop value.
    load_setup(32'd200, 32'd150, 32'd5, 16'd1, 1'b0);
    pulse_start();
    check_point("rev0", 32'd150, 1'b1, 1'b0, 1'b0);
    step();
    check_point("rev_done", 32'd150, 1'b0, 1'b1, 1'b0);

    // Continuous: 0,10,20,0,10,20,0,10 then abort at 10.
    load_setup(32'd0, 32'd20, 32'd10, 16'd1, 1'b1);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      check_point("cont", 32'd10 * 32'(i % 3), 1'b1, 1'b0, (i == 3 || i == 6));
      if (i == 7) abort = 1'b1;
      step();
    end
    abort = 1'b0;
    check_point("abort", 32'd10, 1'b0, 1'b0, 1'b0);
    step();
    check_point("abort_hold", 32'd10, 1'b0, 1'b0, 1'b0);

    // Start and abort together in IDLE: nothing starts.
    load_setup(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check_point("start_abort", 32'd10, 1'b0, 1'b0, 1'b0);
    step();
    check_point("start_abort2", 32'd10, 1'b0, 1'b0, 1'b0);

    // Mid-sweep start re-pulse and setup changes are ignored.
    pulse_start();
    for (int i = 0; i < 12; i++) begin
      check_point("ignore", 32'd100 + 32'd10 * 32'(i / 3), 1'b1, 1'b0, 1'b0);
      if (i == 4) begin
        start = 1'b1;
        step_inc = 32'd1;
        start_step = 32'd0;
        dwell_cycles = 16'd7;
      end
      if (i == 5) start = 1'b0;
      step();
    end
    check_point("ignore_done", 32'd130, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between edges, then a fresh sweep.
    load_setup(32'd100, 32'd130, 32'd10, 16'd3, 1'b0);
    pulse_start();
    step();
    step();
    step();
    check_point("pre_rst", 32'd110, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_point("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check_point("post_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    load_setup(32'd5, 32'd7, 32'd1, 16'd2, 1'b0);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check_point("new", 32'd5 + 32'(i / 2), 1'b1, 1'b0, 1'b0);
      step();
    end
    check_point("new_done", 32'd7, 1'b0, 1'b1, 1'b0);
    step();
    check_point("new_after", 32'd7, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dds_freq_sweep
